spi_master: RTL and testbench

// - Memory-mapped SPI master (mode 0, 8-bit, MSB first) responding on the SoC valid/ready peripheral bus.
// - Decoded by the SoC address router like bram/uart/clint; drives an external SPI flash or sensor.
// - Completes one request per ready pulse; data writes stall while a transfer is in progress.

---
 rtl/spi_master.sv | 168 ++++++++++++++++
 tb/tb_spi_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, 8-bit, MSB first) on the valid/ready peripheral bus.
// Optional feature: define SPI_LOOPBACK_EN to make CTRL bit1 route MOSI back into the receive path.
module spi_master #(
    parameter logic [15:0] DIV_RESET = 16'd3,
    parameter int          ADDR_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_valid,
    input  logic        spi_instr,
    input  logic [31:0] spi_addr,
    input  logic [31:0] spi_wdata,
    input  logic [3:0]  spi_wstrb,
    output logic [31:0] spi_rdata,
    output logic        spi_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);
    typedef enum logic [1:0] {IDLE, LEAD, TRAIL, DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] div_reg, div_lat_reg, cnt_reg;
    logic [1:0]  ctrl_reg;
    logic [7:0]  rx_data_reg, shift_reg, pend_data_reg;
    logic        rx_valid_reg, pend_reg, sample_reg;
    logic [2:0]  bit_cnt_reg;
    logic        miso_meta_reg, miso_sync_reg;

    logic        busy, tick, last_bit;
    logic        req, is_write, in_range, data_wr, stall, start, miso_bit;
    logic [1:0]  sel;
    logic [7:0]  start_byte;
    logic        unused_bits;

    // A request is ignored while its own ready is still showing or a write is parked.
    assign req        = spi_valid && !spi_ready && !pend_reg;
    assign is_write   = |spi_wstrb;
    assign in_range   = (spi_addr[31:ADDR_BITS] == '0);
    assign sel        = spi_addr[3:2];
    assign data_wr    = req && is_write && in_range && (sel == 2'd0) && spi_wstrb[0];
    assign stall      = data_wr && (state_reg != IDLE);
    assign start      = (state_reg == IDLE) && (pend_reg || data_wr);
    assign start_byte = pend_reg ? pend_data_reg : spi_wdata[7:0];
    assign spi_cs_n   = ~ctrl_reg[0];
    assign unused_bits = ^{spi_instr, spi_wdata[31:16], spi_addr[1:0], spi_wstrb[3:2]};

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = ctrl_reg[1] ? spi_mosi : miso_sync_reg;
`else
    assign miso_bit = miso_sync_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LEAD;
            LEAD:    if (tick) state_next = TRAIL;
            TRAIL:   if (tick) state_next = last_bit ? DONE : LEAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        tick     = ((state_reg == LEAD) || (state_reg == TRAIL)) && (cnt_reg == div_lat_reg);
        last_bit = (bit_cnt_reg == 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_rdata     <= '0;
            spi_ready     <= 1'b0;
            spi_sclk      <= 1'b0;
            spi_mosi      <= 1'b0;
            div_reg       <= DIV_RESET;
            div_lat_reg   <= DIV_RESET;
            cnt_reg       <= '0;
            ctrl_reg      <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            shift_reg     <= '0;
            sample_reg    <= 1'b0;
            bit_cnt_reg   <= '0;
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
            miso_meta_reg <= 1'b0;
            miso_sync_reg <= 1'b0;
        end else begin
            miso_meta_reg <= spi_miso;
            miso_sync_reg <= miso_meta_reg;

            // A parked DATA write is acknowledged in the same cycle its transfer launches.
            spi_ready <= (req && !stall) || (start && pend_reg);
            if (stall) begin
                pend_reg      <= 1'b1;
                pend_data_reg <= spi_wdata[7:0];
            end else if (start && pend_reg) begin
                pend_reg <= 1'b0;
            end

            spi_rdata <= '0;
            if (req && !is_write && in_range) begin
                case (sel)
                    2'd0:    spi_rdata <= {24'd0, rx_data_reg};
                    2'd1:    spi_rdata <= {30'd0, rx_valid_reg, busy};
                    2'd2:    spi_rdata <= {16'd0, div_reg};
                    default: spi_rdata <= {30'd0, ctrl_reg};
                endcase
            end

            if (req && is_write && in_range) begin
                if (sel == 2'd2) begin
                    if (spi_wstrb[0]) div_reg[7:0]  <= spi_wdata[7:0];
                    if (spi_wstrb[1]) div_reg[15:8] <= spi_wdata[15:8];
                end
                if ((sel == 2'd3) && spi_wstrb[0]) begin
                    ctrl_reg[0] <= spi_wdata[0];
`ifdef SPI_LOOPBACK_EN
                    ctrl_reg[1] <= spi_wdata[1];
`endif
                end
            end

            // Completion beats a simultaneous DATA read when updating rx_valid.
            if (state_reg == DONE) begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= shift_reg;
            end else if (req && !is_write && in_range && (sel == 2'd0)) begin
                rx_valid_reg <= 1'b0;
            end

            if (start) begin
                shift_reg   <= start_byte;
                spi_mosi    <= start_byte[7];
                bit_cnt_reg <= 3'd7;
                cnt_reg     <= '0;
                div_lat_reg <= div_reg;
                spi_sclk    <= 1'b0;
            end else if ((state_reg == LEAD) || (state_reg == TRAIL)) begin
                if (!tick) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end else begin
                    cnt_reg <= '0;
                    if (state_reg == LEAD) begin
                        spi_sclk   <= 1'b1;
                        sample_reg <= miso_bit;
                    end else begin
                        // The sampled bit enters at bit0 as the outgoing MSB leaves.
                        spi_sclk  <= 1'b0;
                        shift_reg <= {shift_reg[6:0], sample_reg};
                        if (!last_bit) begin
                            spi_mosi    <= shift_reg[6];
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master: bus reads/writes, SPI waveform and timing against
// the register-map and transfer-timing rules.
module tb_spi_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        spi_valid, spi_instr, spi_ready, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
    logic [31:0] spi_addr, spi_wdata, spi_rdata;
    logic [3:0]  spi_wstrb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

`ifdef SPI_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master dut (
        .clk(clk), .rst(rst), .spi_valid(spi_valid), .spi_instr(spi_instr),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wstrb(spi_wstrb),
        .spi_rdata(spi_rdata), .spi_ready(spi_ready), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    // Mode-0 slave: presents its MSB up front and advances on every falling SCLK.
    logic [15:0] slave_sh;
    assign spi_miso = slave_sh[15];
    always @(negedge spi_sclk) slave_sh = {slave_sh[14:0], 1'b0};

    int   rise_q[$];
    int   fall_q[$];
    logic mosi_q[$];
    logic sclk_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (spi_sclk && !sclk_prev) begin
            rise_q.push_back(cyc);
            mosi_q.push_back(spi_mosi);
        end
        if (!spi_sclk && sclk_prev) fall_q.push_back(cyc);
        sclk_prev = spi_sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lat = cycles from the capture edge until ready is visible (1 = ready in the next cycle).
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r, output int lat, output int cap);
        spi_addr = a; spi_wdata = d; spi_wstrb = s; spi_instr = 1'($urandom_range(0, 1));
        spi_valid = 1'b1;
        @(posedge clk); #1;
        cap = cyc;
        lat = 1;
        while (!spi_ready && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (spi_ready !== 1'b1) check("bus_ready_seen", {31'd0, spi_ready}, 32'd1);
        r = spi_rdata;
        // Valid is held through the ready cycle, as a router would.
        @(posedge clk); #1;
        spi_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int cap);
        logic [31:0] r;
        int lat;
        bus(a, d, s, r, lat, cap);
        check($sformatf("wr_lat@%0h", a), lat, 1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        int lat, cap;
        bus(a, 32'd0, 4'd0, d, lat, cap);
        check($sformatf("rd_lat@%0h", a), lat, 1);
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int n = 0;
        do begin
            rd(32'h4, st);
            n++;
        end while (st[0] && n < 2000);
        if (st[0]) check("idle_timeout", st[0], 0);
    endtask

    task automatic clear_mon();
        rise_q.delete(); fall_q.delete(); mosi_q.delete();
    endtask

    // Takes the next 8 SCLK pulses: every phase is d+1 clocks, MOSI carries tx MSB first.
    task automatic check_xfer(input string nm, input logic [7:0] tx, input int d, input int start);
        logic [7:0] seen;
        int r, f, pf;
        check({nm, "_pulses"}, {31'd0, (rise_q.size() >= 8 && fall_q.size() >= 8)}, 32'd1);
        if (rise_q.size() < 8 || fall_q.size() < 8) return;
        seen = '0;
        pf = 0;
        for (int i = 0; i < 8; i++) begin
            r = rise_q.pop_front();
            f = fall_q.pop_front();
            seen = {seen[6:0], mosi_q.pop_front()};
            if (i == 0) check({nm, "_first_rise"}, r - start, d + 1);
            else        check($sformatf("%s_low%0d", nm, i), r - pf, d + 1);
            check($sformatf("%s_high%0d", nm, i), f - r, d + 1);
            pf = f;
        end
        check({nm, "_mosi"}, seen, tx);
        $display("xfer %s tx=%02h div=%0d start=%0d", nm, tx, d, start);
    endtask

    task automatic do_xfer(input string nm, input logic [7:0] tx, input logic [7:0] sb,
                           input logic [7:0] exp_rx, input int d);
        logic [31:0] st, v;
        int cap;
        clear_mon();
        slave_sh = {sb, 8'h00};
        wr(32'h0, {24'd0, tx}, 4'b0001, cap);
        wait_idle(st);
        check({nm, "_status_done"}, st, 32'h2);
        rd(32'h0, v);
        check({nm, "_rx"}, v, {24'd0, exp_rx});
        rd(32'h4, st);
        check({nm, "_status_after"}, st, 32'h0);
        check_xfer(nm, tx, d, cap);
    endtask

    logic [31:0] v, st;
    int cap, cap1, cap2, lat, n;
    logic [7:0] tx, rx, rxa, rxb;
    int d;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; spi_valid = 1'b0; spi_instr = 1'b0; spi_addr = '0; spi_wdata = '0; spi_wstrb = '0;
        slave_sh = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_ready", spi_ready, 0);
        check("rst_rdata", spi_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        rd(32'h8, v); check("rst_divider", v, 32'd3);
        rd(32'h4, v); check("rst_status", v, 32'd0);
        rd(32'hC, v); check("rst_ctrl", v, 32'd0);
        rd(32'h0, v); check("rst_data", v, 32'd0);

        wr(32'hC, 32'h1, 4'b0001, cap);
        check("cs_asserted", spi_cs_n, 0);
        do_xfer("basic", 8'hA5, 8'h3C, 8'h3C, 3);

        for (int it = 0; it < 6; it++) begin
            d = (it == 0) ? 9 : int'($urandom_range(2, 8));
            tx = 8'($urandom);
            rx = 8'($urandom);
            wr(32'h8, d, 4'b0011, cap);
            rd(32'h8, v);
            check($sformatf("div_rb%0d", it), v, d);
            do_xfer($sformatf("rand%0d", it), tx, rx, rx, d);
        end

        // DIVIDER written mid-transfer only applies to the following transfer.
        wr(32'h8, 32'd2, 4'b0011, cap);
        clear_mon();
        tx = 8'($urandom);
        slave_sh = '0;
        wr(32'h0, {24'd0, tx}, 4'b0001, cap1);
        wr(32'h8, 32'd5, 4'b0011, cap);
        wait_idle(st);
        rd(32'h0, v);
        check("divlate_rx", v, 32'd0);
        check_xfer("divlate", tx, 2, cap1);
        do_xfer("div5", 8'h96, 8'h69, 8'h69, 5);

        // Back-to-back writes: the second is parked until the first transfer has fully finished.
        wr(32'h8, 32'd2, 4'b0011, cap);
        clear_mon();
        rxa = 8'($urandom);
        rxb = 8'($urandom);
        slave_sh = {rxa, rxb};
        wr(32'h0, 32'h11, 4'b0001, cap1);
        bus(32'h0, 32'h22, 4'b0001, v, lat, cap2);
        check("stall_ready_edge", cap2 + lat - 1, cap1 + 16 * 3 + 2);
        wait_idle(st);
        check("stall_status", st, 32'h2);
        rd(32'h0, v);
        check("stall_rx", v, {24'd0, rxb});
        check_xfer("stall_a", 8'h11, 2, cap1);
        check_xfer("stall_b", 8'h22, 2, cap1 + 16 * 3 + 2);

        // DATA write without byte 0 enabled must not launch anything.
        clear_mon();
        wr(32'h0, 32'hFF, 4'b0010, cap);
        repeat (10) @(posedge clk);
        #1;
        rd(32'h4, v);
        check("noop_status", v, 32'h0);
        check("noop_pulses", rise_q.size(), 0);

        wr(32'h8, 32'hABCD, 4'b0001, cap);
        rd(32'h8, v); check("div_strb0", v, 32'h00CD);
        wr(32'h8, 32'h1234, 4'b0010, cap);
        rd(32'h8, v); check("div_strb1", v, 32'h12CD);
        wr(32'h8, 32'd2, 4'b0011, cap);

        bus(32'h10, 32'd0, 4'd0, v, lat, cap);
        check("oor_rdata", v, 32'd0);
        check("oor_lat", lat, 1);
        wr(32'h20, 32'hFFFF_FFFF, 4'b1111, cap);
        wr(32'h18, 32'h7, 4'b1111, cap);
        wr(32'h1C, 32'h0, 4'b1111, cap);
        wr(32'h10, 32'h55, 4'b1111, cap);
        rd(32'h8, v); check("oor_div_kept", v, 32'd2);
        rd(32'hC, v); check("oor_ctrl_kept", v, 32'd1);
        rd(32'h4, v); check("oor_no_xfer", v, 32'd0);

        wr(32'hC, 32'h3, 4'b0001, cap);
        rd(32'hC, v);
        check("ctrl_lb_rb", v, LB ? 32'h3 : 32'h1);
        do_xfer("loopback", 8'h5A, 8'h00, LB ? 8'h5A : 8'h00, 2);
        wr(32'hC, 32'h1, 4'b0001, cap);

        // Asynchronous reset while SCLK is high in the middle of an all-ones byte.
        wr(32'h8, 32'd3, 4'b0011, cap);
        wr(32'h0, 32'hFF, 4'b0001, cap);
        n = 0;
        while (!spi_sclk && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_sclk_high", spi_sclk, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_sclk", spi_sclk, 0);
        check("midrst_mosi", spi_mosi, 0);
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_ready", spi_ready, 0);
        check("midrst_rdata", spi_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        rd(32'h4, v); check("midrst_status", v, 32'd0);
        rd(32'h8, v); check("midrst_div", v, 32'd3);
        rd(32'hC, v); check("midrst_ctrl", v, 32'd0);
        rd(32'h0, v); check("midrst_data", v, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_quiet", rise_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
